// File: rtl/dm_arbiter.sv
// Two-master arbiter for the shared data-memory port: combinational grant,
// round-robin with a bounded burst per owner, registered read data back to the winner.
module dm_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_type,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_type,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic [2:0]    dm_type,
  input  logic [DW-1:0] dm_dout,

  output logic [1:0]    owner
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic sel1;
  logic gnt0;
  logic gnt1;

  // Burst length saturates at MAX_BURST so a long solo run cannot wrap the counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    sat_inc = (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  // Winner depends only on requests and registered state, never on a grant.
  always_comb begin
    sel1 = 1'b0;
    if (m1_req && !m0_req) begin
      sel1 = 1'b1;
    end else if (m1_req && m0_req) begin
      case (st_q)
        OWN0:    sel1 = (cnt_q >= CNT_MAX);
        OWN1:    sel1 = (cnt_q <  CNT_MAX);
        default: sel1 = 1'b0;
      endcase
    end
    gnt0 = !rst && m0_req && !sel1;
    gnt1 = !rst && m1_req &&  sel1;
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_din  = '0;
    dm_type = 3'b000;
    if (gnt1) begin
      dm_we   = m1_we;
      dm_addr = m1_addr;
      dm_din  = m1_wdata;
      dm_type = m1_type;
    end else if (gnt0) begin
      dm_we   = m0_we;
      dm_addr = m0_addr;
      dm_din  = m0_wdata;
      dm_type = m0_type;
    end
  end

  always_comb begin
    st_d  = IDLE;
    cnt_d = '0;
    if (gnt0) begin
      if (st_q == OWN0) begin
        st_d  = OWN0;
        cnt_d = sat_inc(cnt_q);
      end else begin
        st_d  = OWN0;
        cnt_d = CNT_ONE;
      end
    end else if (gnt1) begin
      if (st_q == OWN1) begin
        st_d  = OWN1;
        cnt_d = sat_inc(cnt_q);
      end else begin
        st_d  = OWN1;
        cnt_d = CNT_ONE;
      end
    end
  end

  // Read data is captured on the granted read's edge and held until the next read on that port.
  always_comb begin
    m0_rvalid_d = gnt0 && !m0_we;
    m1_rvalid_d = gnt1 && !m1_we;
    m0_rdata_d  = m0_rvalid_d ? dm_dout : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? dm_dout : m1_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign owner     = st_q;

endmodule
